// File: rtl/cv32e40p_pkg.sv
// Shared types for the CV32E40P fetch path: the fetch queue entry layout,
// its cleared value and a constructor that applies the error-entry rule.
package cv32e40p_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compressed;
    logic        illegal_c;
    logic        err;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_ENTRY_RST = '{
    instr:      32'h0000_0000,
    pc:         32'h0000_0000,
    compressed: 1'b0,
    illegal_c:  1'b0,
    err:        1'b0
  };

  // Build a queue entry; a faulted fetch keeps only its PC and the error flag
  // so that ID never decodes garbage bits from an aborted bus transfer.
  function automatic fetch_entry_t make_fetch_entry(
    input logic [31:0] instr,
    input logic [31:0] pc,
    input logic        compressed,
    input logic        illegal_c,
    input logic        err
  );
    fetch_entry_t e;
    e.pc = pc;
    if (err) begin
      e.instr      = 32'h0000_0000;
      e.compressed = 1'b0;
      e.illegal_c  = 1'b0;
      e.err        = 1'b1;
    end else begin
      e.instr      = instr;
      e.compressed = compressed;
      e.illegal_c  = illegal_c;
      e.err        = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/cv32e40p_fetch_queue.sv
// Fetch queue between the aligner/decompressor and ID. A flat circular FIFO of
// fetch_entry_t with flush priority, halt gating of the head and optional
// blocking after a faulted fetch until the next flush.
module cv32e40p_fetch_queue
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter bit          ERR_BLOCK = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       halt_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [31:0]                in_pc_i,
  input  logic                       in_compressed_i,
  input  logic                       in_illegal_c_i,
  input  logic                       in_err_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [31:0]                out_pc_o,
  output logic                       out_compressed_o,
  output logic                       out_illegal_c_o,
  output logic                       out_err_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0]       rptr_r;
  logic [PTR_W-1:0]       wptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   blocked_r;

  logic                   push_s;
  logic                   pop_s;
  logic                   not_empty_s;
  logic [CNT_W-1:0]       count_nxt_s;
  logic                   blocked_nxt_s;
  fetch_entry_t           head_s;
  fetch_entry_t           wr_entry_s;

  // Handshake qualifiers; in_ready depends only on registered state.
  always_comb begin
    not_empty_s = (count_r != {CNT_W{1'b0}});
    in_ready_o  = (count_r < CNT_W'(DEPTH)) && !blocked_r;
    out_valid_o = not_empty_s && !halt_i && !flush_i;
    push_s      = in_valid_i && in_ready_o && !flush_i;
    pop_s       = out_valid_o && out_ready_i;
    busy_o      = not_empty_s;
    count_o     = count_r;
  end

  // Head entry drives the ID-side data; storage is cleared on reset so it is never X.
  always_comb begin
    head_s           = mem_r[rptr_r];
    out_instr_o      = head_s.instr;
    out_pc_o         = head_s.pc;
    out_compressed_o = head_s.compressed;
    out_illegal_c_o  = head_s.illegal_c;
    out_err_o        = head_s.err;
  end

  // Entry to be written, with faulted fetches reduced to PC plus error flag.
  always_comb begin
    wr_entry_s = make_fetch_entry(in_instr_i, in_pc_i, in_compressed_i,
                                  in_illegal_c_i, in_err_i);
  end

  // Next occupancy: +1 on push, -1 on pop, unchanged when both or neither.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next blocked state: set by an accepted error push when blocking is enabled.
  always_comb begin
    blocked_nxt_s = blocked_r;
    if (!ERR_BLOCK) begin
      blocked_nxt_s = 1'b0;
    end else if (push_s && in_err_i) begin
      blocked_nxt_s = 1'b1;
    end else begin
      blocked_nxt_s = blocked_r;
    end
  end

  // Pointer, occupancy and blocked registers; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_r    <= {PTR_W{1'b0}};
      wptr_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      blocked_r <= 1'b0;
    end else if (flush_i) begin
      rptr_r    <= {PTR_W{1'b0}};
      wptr_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      blocked_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1'b1);
      end
      count_r   <= count_nxt_s;
      blocked_r <= blocked_nxt_s;
    end
  end

  // Entry storage; only a qualified push writes, so flush leaves contents untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[PTR_W'(i)] <= FETCH_ENTRY_RST;
      end
    end else if (push_s) begin
      mem_r[wptr_r] <= wr_entry_s;
    end
  end

endmodule
